// File: rtl/mesif_pkg.sv
// Shared encodings for the MESIF FSM and the bus-side snoop controller.
package mesif_pkg;

    // Bus command codes; 0 and 5..7 are not legal requests.
    typedef enum logic [2:0] {
        BUS_NONE  = 3'd0,
        BUS_READ  = 3'd1,
        BUS_WRITE = 3'd2,
        BUS_INVAL = 3'd3,
        BUS_RWIM  = 3'd4
    } bus_op_e;

    // Snoop result codes; code 3 is reserved and handled as HIT.
    typedef enum logic [1:0] {
        SNOOP_NOHIT = 2'd0,
        SNOOP_HIT   = 2'd1,
        SNOOP_HITM  = 2'd2,
        SNOOP_RSVD  = 2'd3
    } snoop_res_e;

    // bus_snoop_ctrl state encoding.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_BACKOFF = 3'd3,
        ST_RESP    = 3'd4
    } bsc_state_e;

    // True for the four op codes that are driven onto the bus.
    function automatic logic is_legal_op(input logic [2:0] op);
        return (op >= 3'(BUS_READ)) && (op <= 3'(BUS_RWIM));
    endfunction

endpackage

// File: rtl/snoop_timer.sv
// Loadable down-counter; expired flags the last counted cycle (count <= 1).
module snoop_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic             expired
);

    logic [CNT_W-1:0] cnt;

    // Load has priority over decrement; counting stops at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_value;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == CNT_W'(1)) || (cnt == '0);

endmodule

// File: rtl/bus_snoop_ctrl.sv
// Bus-side stage behind the MESIF FSM: issues one request, collects the snoop
// result (with HITM back-off/retry and a snoop timeout) and returns it.
module bus_snoop_ctrl
    import mesif_pkg::*;
#(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned SNOOP_TIMEOUT = 15,
    parameter int unsigned BACKOFF_CYC   = 4,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              bus_valid,
    output logic [2:0]        bus_op,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              snoop_valid,
    input  logic [1:0]        snoop_res,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_snoop,
    output logic              rsp_timeout,
    output logic [1:0]        rsp_retries
);

    localparam int unsigned TO_W    = $clog2(SNOOP_TIMEOUT + 1);
    localparam int unsigned BO_W    = $clog2(BACKOFF_CYC + 1);
    localparam int unsigned RETRY_W = 2;

    bsc_state_e state, state_next;

    logic [2:0]         op_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [RETRY_W-1:0] retry_q;
    snoop_res_e         rsp_snoop_q;
    logic               rsp_timeout_q;

    logic       accept, retry_inc, set_rsp, rsp_to_next;
    logic       to_load, bo_load, to_expired, bo_expired;
    snoop_res_e rsp_snoop_next, snoop_norm;

    snoop_timer #(.CNT_W(TO_W)) u_timeout (
        .clk        (clk),
        .rst        (rst),
        .load       (to_load),
        .load_value (TO_W'(SNOOP_TIMEOUT)),
        .dec        (state == ST_WAIT),
        .expired    (to_expired)
    );

    snoop_timer #(.CNT_W(BO_W)) u_backoff (
        .clk        (clk),
        .rst        (rst),
        .load       (bo_load),
        .load_value (BO_W'(BACKOFF_CYC)),
        .dec        (state == ST_BACKOFF),
        .expired    (bo_expired)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the strobes that update the datapath registers.
    always_comb begin
        state_next     = state;
        accept         = 1'b0;
        retry_inc      = 1'b0;
        set_rsp        = 1'b0;
        rsp_snoop_next = SNOOP_NOHIT;
        rsp_to_next    = 1'b0;
        to_load        = 1'b0;
        bo_load        = 1'b0;
        snoop_norm     = snoop_res_e'(snoop_res);
        if (snoop_norm == SNOOP_RSVD) begin
            snoop_norm = SNOOP_HIT;
        end
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (is_legal_op(req_op)) begin
                        state_next = ST_ISSUE;
                    end else begin
                        // Illegal ops skip the bus entirely and answer NOHIT.
                        state_next = ST_RESP;
                        set_rsp    = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (op_q == 3'(BUS_WRITE)) begin
                    state_next = ST_RESP;
                    set_rsp    = 1'b1;
                end else begin
                    state_next = ST_WAIT;
                    to_load    = 1'b1;
                end
            end
            ST_WAIT: begin
                if (snoop_valid) begin
                    if (snoop_norm == SNOOP_HITM && retry_q < RETRY_W'(MAX_RETRY)) begin
                        state_next = ST_BACKOFF;
                        bo_load    = 1'b1;
                        retry_inc  = 1'b1;
                    end else begin
                        state_next     = ST_RESP;
                        set_rsp        = 1'b1;
                        rsp_snoop_next = snoop_norm;
                    end
                end else if (to_expired) begin
                    state_next  = ST_RESP;
                    set_rsp     = 1'b1;
                    rsp_to_next = 1'b1;
                end
            end
            ST_BACKOFF: begin
                if (bo_expired) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Request latch, retry counter and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q          <= '0;
            addr_q        <= '0;
            retry_q       <= '0;
            rsp_snoop_q   <= SNOOP_NOHIT;
            rsp_timeout_q <= 1'b0;
        end else begin
            if (accept) begin
                retry_q <= '0;
                // Only legal ops reach the bus, so only they update bus_op/bus_addr.
                if (is_legal_op(req_op)) begin
                    op_q   <= req_op;
                    addr_q <= req_addr;
                end
            end
            if (retry_inc) begin
                retry_q <= retry_q + 1'b1;
            end
            if (set_rsp) begin
                rsp_snoop_q   <= rsp_snoop_next;
                rsp_timeout_q <= rsp_to_next;
            end
        end
    end

    assign req_ready   = (state == ST_IDLE);
    assign bus_valid   = (state == ST_ISSUE);
    assign bus_op      = op_q;
    assign bus_addr    = addr_q;
    assign rsp_valid   = (state == ST_RESP);
    assign rsp_snoop   = rsp_snoop_q;
    assign rsp_timeout = rsp_timeout_q;
    assign rsp_retries = retry_q;

endmodule
